// File: rtl/mixcol_pkg.sv
// Shared types and GF(2^8) helpers for the MixColumns engine.
package mixcol_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mc_state_e;

   // Low byte of the AES reduction polynomial 0x11B, folded in on overflow.
   localparam logic [7:0] GF_RED = 8'h1B;

   function automatic logic [7:0] x2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
   endfunction

   function automatic logic [7:0] x3(input logic [7:0] b);
      return x2(b) ^ b;
   endfunction

   function automatic logic [7:0] x9(input logic [7:0] b);
      return x2(x2(x2(b))) ^ b;
   endfunction

   function automatic logic [7:0] x0B(input logic [7:0] b);
      return x2(x2(x2(b))) ^ x2(b) ^ b;
   endfunction

   function automatic logic [7:0] x0D(input logic [7:0] b);
      return x2(x2(x2(b))) ^ x2(x2(b)) ^ b;
   endfunction

   function automatic logic [7:0] x0E(input logic [7:0] b);
      return x2(x2(x2(b))) ^ x2(x2(b)) ^ x2(b);
   endfunction

endpackage

// File: rtl/mixcol_column.sv
// One 32-bit column through MixColumns or InvMixColumns; row 0 is the top byte.
module mixcol_column
   import mixcol_pkg::*;
(
   input  logic [31:0] col_i,
   input  logic        inv_i,
   output logic [31:0] col_o
);

   logic [7:0]  a0, a1, a2, a3;
   logic [31:0] fwd;
   logic [31:0] inv;

   assign {a0, a1, a2, a3} = col_i;

   // Forward circulant {02 03 01 01}.
   assign fwd = {x2(a0) ^ x3(a1) ^ a2     ^ a3,
                 a0     ^ x2(a1) ^ x3(a2) ^ a3,
                 a0     ^ a1     ^ x2(a2) ^ x3(a3),
                 x3(a0) ^ a1     ^ a2     ^ x2(a3)};

   // Inverse circulant {0E 0B 0D 09}.
   assign inv = {x0E(a0) ^ x0B(a1) ^ x0D(a2) ^ x9(a3),
                 x9(a0)  ^ x0E(a1) ^ x0B(a2) ^ x0D(a3),
                 x0D(a0) ^ x9(a1)  ^ x0E(a2) ^ x0B(a3),
                 x0B(a0) ^ x0D(a1) ^ x9(a2)  ^ x0E(a3)};

   assign col_o = inv_i ? inv : fwd;

endmodule

// File: rtl/mixcol_engine.sv
// MixColumns / InvMixColumns engine with valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for a block, s_ready high
//   BUSY  | transforming COLS_PER_CYCLE columns per cycle in the working register
//   DONE  | result held on m_state with m_valid high until m_ready
//
// With COLS_PER_CYCLE=4 the whole block is transformed in the accept cycle and
// registered straight into DONE, so BUSY is never visited.
module mixcol_engine
   import mixcol_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         s_inv,
   input  logic [127:0] s_state,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_state
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam bit         ONE_SHOT = (COLS_PER_CYCLE == 4);
   localparam logic [1:0] LAST_CNT = 2'(4 / COLS_PER_CYCLE - 1);

   mc_state_e    state_q;
   logic [1:0]   cnt_q;
   logic [127:0] work_q;
   logic [127:0] work_d;
   logic [127:0] m_state_q;
   logic         m_valid_q;
   logic         inv_q;
   logic         live_q;
   logic         accept;

   logic [127:0] src_blk;
   logic         col_inv;
   logic [1:0]   col_idx [COLS_PER_CYCLE];
   logic [31:0]  col_in  [COLS_PER_CYCLE];
   logic [31:0]  col_out [COLS_PER_CYCLE];

   function automatic logic [31:0] col_sel(input logic [127:0] blk, input logic [1:0] idx);
      logic [31:0] c;
      case (idx)
         2'd0:    c = blk[127:96];
         2'd1:    c = blk[95:64];
         2'd2:    c = blk[63:32];
         default: c = blk[31:0];
      endcase
      return c;
   endfunction

   // Single-cycle mode works on the incoming block; otherwise on the latched copy.
   assign src_blk = ONE_SHOT ? s_state : work_q;
   assign col_inv = ONE_SHOT ? s_inv   : inv_q;

   // Column selection: slot j handles column counter*COLS_PER_CYCLE + j.
   always_comb begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         col_idx[j] = cnt_q * 2'(COLS_PER_CYCLE) + 2'(j);
         col_in[j]  = col_sel(src_blk, col_idx[j]);
      end
   end

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      mixcol_column u_col (
         .col_i (col_in[g]),
         .inv_i (col_inv),
         .col_o (col_out[g])
      );
   end

   // Write transformed columns back over their slots in the working block.
   always_comb begin
      work_d = work_q;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         case (col_idx[j])
            2'd0:    work_d[127:96] = col_out[j];
            2'd1:    work_d[95:64]  = col_out[j];
            2'd2:    work_d[63:32]  = col_out[j];
            default: work_d[31:0]   = col_out[j];
         endcase
      end
   end

   // Ready is held low until the first edge after reset release.
   always_comb begin
      s_ready = 1'b0;
      if (live_q) begin
         case (state_q)
            IDLE:    s_ready = 1'b1;
            DONE:    s_ready = m_ready;
            default: s_ready = 1'b0;
         endcase
      end
   end

   assign accept  = s_valid && s_ready;
   assign m_valid = m_valid_q;
   assign m_state = m_state_q;

   // Control FSM, working register and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         m_state_q <= '0;
         m_valid_q <= 1'b0;
         inv_q     <= 1'b0;
         live_q    <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (accept) begin
            inv_q <= s_inv;
            cnt_q <= '0;
            if (ONE_SHOT) begin
               work_q    <= work_d;
               m_state_q <= work_d;
               m_valid_q <= 1'b1;
               state_q   <= DONE;
            end else begin
               work_q    <= s_state;
               m_valid_q <= 1'b0;
               state_q   <= BUSY;
            end
         end else begin
            case (state_q)
               BUSY: begin
                  work_q <= work_d;
                  if (cnt_q == LAST_CNT) begin
                     m_state_q <= work_d;
                     m_valid_q <= 1'b1;
                     cnt_q     <= '0;
                     state_q   <= DONE;
                  end else begin
                     cnt_q <= cnt_q + 2'd1;
                  end
               end
               DONE: begin
                  if (m_ready) begin
                     m_valid_q <= 1'b0;
                     state_q   <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mixcol_engine.sv
// Bench: three engines (1, 2 and 4 columns per cycle) on one clock, checked
// against a bit-serial GF(2^8) reference through an expected-result queue.
module tb_mixcol_engine;

   logic         clk;
   logic         reset_n;
   logic         sv [3];
   logic         sr [3];
   logic         si [3];
   logic [127:0] ss [3];
   logic         mv [3];
   logic         mr [3];
   logic [127:0] ms [3];

   int checks;
   int errors;
   logic [127:0] exp_q [$];

   localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_c6c6c6c6_01010101;
   localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_01010101;

   mixcol_engine #(.COLS_PER_CYCLE(1)) u_c1 (
      .clk(clk), .reset_n(reset_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_inv(si[0]),
      .s_state(ss[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_state(ms[0]));
   mixcol_engine #(.COLS_PER_CYCLE(2)) u_c2 (
      .clk(clk), .reset_n(reset_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_inv(si[1]),
      .s_state(ss[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_state(ms[1]));
   mixcol_engine #(.COLS_PER_CYCLE(4)) u_c4 (
      .clk(clk), .reset_n(reset_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_inv(si[2]),
      .s_state(ss[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_state(ms[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cpc(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 4;
   endfunction

   // Edges from accept to m_valid; the 4-wide engine registers on the accept edge.
   function automatic int exp_lat(input int k);
      return (k == 2) ? 0 : 4 / cpc(k);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] blk, input logic inv);
      logic [7:0]   base [4];
      logic [7:0]   a [4];
      logic [7:0]   acc;
      logic [127:0] res;
      if (inv) begin
         base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
      end else begin
         base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
      end
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) a[i] = blk[127 - 8*(4*c + i) -: 8];
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - r + 4) % 4], a[k]);
            res[127 - 8*(4*c + r) -: 8] = acc;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Present the block already on ss/si/sv of engine k until accepted; returns at accept edge + #1.
   task automatic offer(input int k, output bit ok);
      int n;
      n = 0;
      #1;
      while (!sr[k] && n < 30) begin
         @(negedge clk); #1; n++;
      end
      ok = sr[k];
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(input int k, output int n);
      n = 0;
      while (!mv[k] && n < 30) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic xfer(input int k, input logic [127:0] d, input logic inv, input string nm);
      bit ok;
      int n;
      logic [127:0] e;
      @(negedge clk);
      ss[k] = d; si[k] = inv; sv[k] = 1'b1; mr[k] = 1'b1;
      exp_q.push_back(ref_mix(d, inv));
      offer(k, ok);
      sv[k] = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_accept k=%0d s_ready never high", nm, k);
      end
      wait_valid(k, n);
      e = exp_q.pop_front();
      checks++;
      if (mv[k] !== 1'b1 || ms[k] !== e) begin
         errors++;
         $display("FAIL %s k=%0d got v=%b %h want v=1 %h", nm, k, mv[k], ms[k], e);
      end
      checks++;
      if (n != exp_lat(k)) begin
         errors++;
         $display("FAIL %s_latency k=%0d got %0d want %0d", nm, k, n, exp_lat(k));
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sv[k] = 1'b0; si[k] = 1'b0; ss[k] = '0; mr[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (sr[k] !== 1'b0 || mv[k] !== 1'b0 || ms[k] !== '0) begin
            errors++;
            $display("FAIL reset_state k=%0d got rdy=%b v=%b %h want 0 0 0", k, sr[k], mv[k], ms[k]);
         end
      end
      reset_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (sr[k] !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_edge k=%0d got %b want 0", k, sr[k]);
         end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (sr[k] !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_edge k=%0d got %b want 1", k, sr[k]);
         end
      end
   endtask

   task automatic test_fips();
      for (int k = 0; k < 3; k++) begin
         exp_q.delete();
         xfer(k, FIPS_IN, 1'b0, "fips_fwd");
         checks++;
         if (ms[k] !== FIPS_OUT) begin
            errors++;
            $display("FAIL fips_vector k=%0d got %h want %h", k, ms[k], FIPS_OUT);
         end
         xfer(k, FIPS_OUT, 1'b1, "fips_inv");
         checks++;
         if (ms[k] !== FIPS_IN) begin
            errors++;
            $display("FAIL fips_inv_vector k=%0d got %h want %h", k, ms[k], FIPS_IN);
         end
      end
   endtask

   task automatic test_roundtrip();
      logic [127:0] x;
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 3; t++) begin
            x = rand_blk();
            xfer(k, x, 1'b0, "rt_fwd");
            xfer(k, ref_mix(x, 1'b0), 1'b1, "rt_inv");
            checks++;
            if (ms[k] !== x) begin
               errors++;
               $display("FAIL roundtrip k=%0d got %h want %h", k, ms[k], x);
            end
         end
      end
   endtask

   task automatic test_latency();
      logic [127:0] blk, e;
      blk = rand_blk();
      e = ref_mix(blk, 1'b0);
      @(negedge clk);
      ss[0] = blk; si[0] = 1'b0; sv[0] = 1'b1; mr[0] = 1'b0;
      #1;
      checks++;
      if (sr[0] !== 1'b1) begin
         errors++;
         $display("FAIL lat_idle_ready got %b want 1", sr[0]);
      end
      @(posedge clk); #1;
      sv[0] = 1'b0; si[0] = 1'b1; ss[0] = ~blk;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (sr[0] !== 1'b0 || mv[0] !== 1'b0) begin
            errors++;
            $display("FAIL lat_busy_edge%0d got rdy=%b v=%b want 0 0", i, sr[0], mv[0]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (mv[0] !== 1'b1 || ms[0] !== e) begin
         errors++;
         $display("FAIL lat_result got v=%b %h want v=1 %h", mv[0], ms[0], e);
      end
      si[0] = 1'b0;
      mr[0] = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure(input int k);
      logic [127:0] a, b, e;
      bit ok;
      int n;
      a = rand_blk();
      b = rand_blk();
      exp_q.delete();
      @(negedge clk);
      ss[k] = a; si[k] = 1'b0; sv[k] = 1'b1; mr[k] = 1'b0;
      exp_q.push_back(ref_mix(a, 1'b0));
      offer(k, ok);
      ss[k] = b; si[k] = 1'b1;
      wait_valid(k, n);
      checks++;
      if (!ok || mv[k] !== 1'b1) begin
         errors++;
         $display("FAIL bp_first k=%0d got acc=%b v=%b want 1 1", k, ok, mv[k]);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (mv[k] !== 1'b1 || sr[k] !== 1'b0 || ms[k] !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_hold k=%0d cyc=%0d got v=%b rdy=%b %h want 1 0 %h",
                     k, i, mv[k], sr[k], ms[k], exp_q[0]);
         end
      end
      void'(exp_q.pop_front());
      mr[k] = 1'b1;
      exp_q.push_back(ref_mix(b, 1'b1));
      #1;
      checks++;
      if (sr[k] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready k=%0d got %b want 1", k, sr[k]);
      end
      @(posedge clk); #1;
      sv[k] = 1'b0;
      wait_valid(k, n);
      e = exp_q.pop_front();
      checks++;
      if (mv[k] !== 1'b1 || ms[k] !== e || n != exp_lat(k)) begin
         errors++;
         $display("FAIL bp_next k=%0d got v=%b lat=%0d %h want 1 %0d %h",
                  k, mv[k], n, ms[k], exp_lat(k), e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_busy();
      bit ok;
      @(negedge clk);
      ss[0] = rand_blk(); si[0] = 1'b0; sv[0] = 1'b1; mr[0] = 1'b1;
      offer(0, ok);
      sv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (!ok || mv[0] !== 1'b0 || ms[0] !== '0 || sr[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy acc=%b got v=%b rdy=%b %h want 0 0 0", ok, mv[0], sr[0], ms[0]);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (sr[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy_rdy_pre got %b want 0", sr[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (sr[0] !== 1'b1 || mv[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy_release got rdy=%b v=%b want 1 0", sr[0], mv[0]);
      end
      exp_q.delete();
      xfer(0, rand_blk(), 1'b1, "rst_next");
   endtask

   task automatic test_back_to_back();
      logic [127:0] blk, e;
      logic         inv;
      exp_q.delete();
      mr[2] = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i < 16) begin
            blk = rand_blk();
            inv = 1'($urandom_range(0, 1));
            ss[2] = blk; si[2] = inv; sv[2] = 1'b1;
            exp_q.push_back(ref_mix(blk, inv));
         end else begin
            sv[2] = 1'b0;
         end
         #1;
         if (i < 16) begin
            checks++;
            if (sr[2] !== 1'b1) begin
               errors++;
               $display("FAIL stream_ready blk=%0d got %b want 1", i, sr[2]);
            end
         end
         if (i > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (mv[2] !== 1'b1 || ms[2] !== e) begin
               errors++;
               $display("FAIL stream_out blk=%0d got v=%b %h want v=1 %h", i - 1, mv[2], ms[2], e);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fips();
      test_roundtrip();
      test_latency();
      test_backpressure(0);
      test_backpressure(1);
      test_backpressure(2);
      test_reset_busy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
